psum_ofifo: RTL and testbench

//   Output-side collector for the 2D MAC array. Captures the per-column partial

---
 rtl/psum_ofifo_pkg.sv | 13 +
 rtl/psum_ofifo_fifo_lane.sv | 51 +++++
 rtl/psum_ofifo.sv | 67 ++++++
 tb/tb_psum_ofifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/psum_ofifo_pkg.sv
// Shared defaults for the psum output FIFO (array geometry and lane depth).
package psum_ofifo_pkg;

  localparam int unsigned PSUM_BW_DEF = 16;
  localparam int unsigned COL_DEF     = 8;
  localparam int unsigned DEPTH_DEF   = 64;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int unsigned ptr_bits(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/psum_ofifo_fifo_lane.sv
// One column FIFO of the psum output collector.
// Ports: clk, reset (async active-low), wr (write strobe), din (column psum),
//        pop (advance read pointer; caller guarantees non-empty),
//        dout (head entry, combinational), empty, full.
module psum_ofifo_fifo_lane
  import psum_ofifo_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned depth   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               pop,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = ptr_bits(depth);

  logic [psum_bw-1:0] mem [depth];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic               push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A full lane still accepts a write when the same edge frees a slot.
  assign push  = wr && (!full || pop);
  assign dout  = mem[rptr[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Output-side collector for the MAC array: one FIFO per column removes the
// row skew and hands out column-aligned psum rows on a read handshake.
// Ports: clk, reset (async active-low), in (col lanes of psum_bw), wr (per-lane
//        strobe), rd (pop request), o_full (any lane full), o_valid (all lanes
//        non-empty), out (registered row), out_valid (pop pulse), overflow
//        (sticky dropped-write flag).
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned col     = COL_DEF,
  parameter int unsigned depth   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_full,
  output logic                   o_valid,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_valid,
  output logic                   overflow
);

  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [psum_bw*col-1:0] head;
  logic                   pop;
  logic                   drop;

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    psum_ofifo_fifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[gi]),
      .din   (in[psum_bw*gi +: psum_bw]),
      .pop   (pop),
      .dout  (head[psum_bw*gi +: psum_bw]),
      .empty (lane_empty[gi]),
      .full  (lane_full[gi])
    );
  end

  assign o_valid = &(~lane_empty);
  assign o_full  = |lane_full;
  assign pop     = rd && o_valid;
  // Writes to a full lane are lost only when no pop frees a slot this edge.
  assign drop    = (|(wr & lane_full)) && !pop;

  // Output row, pop pulse and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop)  out      <= head;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomised self-checking bench for psum_ofifo against a queue-based model.
module tb_psum_ofifo;

  localparam int BW = 16;
  localparam int NC = 8;
  localparam int DP = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [BW*NC-1:0] in = '0;
  logic [NC-1:0]   wr = '0;
  logic            rd = 1'b0;
  logic            o_full;
  logic            o_valid;
  logic [BW*NC-1:0] out;
  logic            out_valid;
  logic            overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per column plus the registered outputs.
  logic [BW-1:0]    mq [NC][$];
  logic [BW*NC-1:0] m_out = '0;
  logic             m_vld = 1'b0;
  logic             m_ovf = 1'b0;

  always #5 clk = ~clk;

  psum_ofifo #(.psum_bw(BW), .col(NC), .depth(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .wr        (wr),
    .rd        (rd),
    .o_full    (o_full),
    .o_valid   (o_valid),
    .out       (out),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [BW*NC-1:0] got,
                     input logic [BW*NC-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_all_valid();
    for (int c = 0; c < NC; c++)
      if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_any_full();
    for (int c = 0; c < NC; c++)
      if (mq[c].size() == DP) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".o_valid"},   (BW*NC)'(o_valid),   (BW*NC)'(m_all_valid()));
    chk({tag, ".o_full"},    (BW*NC)'(o_full),    (BW*NC)'(m_any_full()));
    chk({tag, ".out"},       out,                 m_out);
    chk({tag, ".out_valid"}, (BW*NC)'(out_valid), (BW*NC)'(m_vld));
    chk({tag, ".overflow"},  (BW*NC)'(overflow),  (BW*NC)'(m_ovf));
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, then compare.
  task automatic step(input string tag, input logic [NC-1:0] w, input logic r,
                      input logic [BW*NC-1:0] d);
    logic          pop;
    logic [NC-1:0] was_full;
    wr = w;
    rd = r;
    in = d;
    @(posedge clk);
    pop = r && m_all_valid();
    for (int c = 0; c < NC; c++) was_full[c] = (mq[c].size() == DP);
    m_vld = pop;
    if (pop)
      for (int c = 0; c < NC; c++) m_out[c*BW +: BW] = mq[c].pop_front();
    for (int c = 0; c < NC; c++)
      if (w[c]) begin
        if (!was_full[c] || pop) mq[c].push_back(d[c*BW +: BW]);
        else                     m_ovf = 1'b1;
      end
    #1;
    check_all(tag);
  endtask

  function automatic logic [BW*NC-1:0] rnd_row();
    logic [BW*NC-1:0] v;
    for (int i = 0; i < BW*NC/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset(input string tag);
    wr = '0;
    rd = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_out = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [BW*NC-1:0] d;
    logic [NC-1:0]    w;

    #12;
    check_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Mid-traffic reset.
    for (int i = 0; i < 10; i++)
      step("pre_rst", NC'($urandom), 1'($urandom), rnd_row());
    do_reset("rst_mid");

    // Skewed fill: lane c writes 16c+k at cycle c+k.
    for (int t = 0; t < NC + 4; t++) begin
      w = '0;
      d = '0;
      for (int c = 0; c < NC; c++)
        if (t - c >= 0 && t - c < 4) begin
          w[c] = 1'b1;
          d[c*BW +: BW] = BW'(16*c + t - c);
        end
      step("skew_fill", w, 1'b0, d);
    end
    for (int k = 0; k < 4; k++) step("skew_pop", '0, 1'b1, '0);
    step("skew_idle", '0, 1'b1, '0);

    // Full and overflow.
    do_reset("rst_full");
    for (int k = 0; k < DP; k++) step("fill", '1, 1'b0, rnd_row());
    step("ovf_wr0", NC'(1), 1'b0, rnd_row());
    for (int k = 0; k < DP; k++) step("drain", '0, 1'b1, '0);

    // Write plus pop on a full lane 3.
    do_reset("rst_wp");
    for (int k = 0; k < DP; k++) step("fill3", NC'(8), 1'b0, rnd_row());
    step("fill_rest", NC'(8'hf7), 1'b0, rnd_row());
    step("wr_pop_full", NC'(8), 1'b1, rnd_row());
    for (int k = 0; k < DP + 1; k++) step("drain3", NC'(8'hf7), 1'b1, rnd_row());

    // Read while lane 5 empty.
    do_reset("rst_empty");
    for (int k = 0; k < 3; k++) step("fill_no5", NC'(8'hdf), 1'b0, rnd_row());
    step("rd_empty", '0, 1'b1, '0);
    step("fill5", NC'(8'h20), 1'b0, rnd_row());
    step("pop_after5", '0, 1'b1, '0);
    step("rd_empty2", '0, 1'b1, '0);

    // Streaming across pointer wrap.
    do_reset("rst_wrap");
    step("prime", '1, 1'b0, rnd_row());
    for (int k = 0; k < 200; k++) step("stream", '1, 1'b1, rnd_row());
    step("stream_last", '0, 1'b1, '0);

    // Random traffic.
    do_reset("rst_rand");
    for (int k = 0; k < 600; k++)
      step("rand", NC'($urandom), ($urandom_range(0, 3) != 0), rnd_row());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
